// File: rtl/uart_arb_pkg.sv
// uart_arb_pkg: shared FSM encoding and width constants for the UART transmit arbiter.
package uart_arb_pkg;
    localparam int DEF_DATA_W = 8;
    localparam int CNT_W = 16;
    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_LOAD      = 3'd1;
    localparam logic [2:0] S_WAIT_BUSY = 3'd2;
    localparam logic [2:0] S_WAIT_DONE = 3'd3;
    localparam logic [2:0] S_HOLD      = 3'd4;
endpackage

// File: rtl/rr_picker.sv
// rr_picker: combinational round-robin pick, searching from last_owner+1 modulo NUM_REQ.
module rr_picker #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_owner,
    output logic [NUM_REQ-1:0] winner,
    output logic [IDX_W-1:0]   win_idx
);
    logic found;
    logic [IDX_W-1:0] cand;
    always_comb begin
        win_idx = '0;
        found = 1'b0;
        cand = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = IDX_W'((int'(last_owner) + k) % NUM_REQ);
            if (!found && req[cand]) begin
                found = 1'b1;
                win_idx = cand;
            end
        end
        winner = found ? (NUM_REQ'(1) << win_idx) : '0;
    end
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin, packet-locked sharing of one UART transmitter among NUM_REQ byte sources.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DATA_W = DEF_DATA_W,
    parameter int BUSY_TIMEOUT = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    input  logic [NUM_REQ-1:0]        req_last,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      tx_start,
    output logic [DATA_W-1:0]         tx_data,
    input  logic                      tx_busy,
    output logic [NUM_REQ-1:0]        grant,
    output logic                      tx_err,
    output logic [CNT_W-1:0]          bytes_sent
);
    localparam int IDX_W = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
    localparam int TMR_W = $clog2(BUSY_TIMEOUT + 1);

    logic [2:0] state;
    logic [IDX_W-1:0] last_owner, owner, win_idx, sel_idx;
    logic [NUM_REQ-1:0] win;
    logic [TMR_W-1:0] timer;
    logic last_q, busy_q, hs, timeout, done;

    rr_picker #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_pick (
        .req(req_valid),
        .last_owner(last_owner),
        .winner(win),
        .win_idx(win_idx)
    );

    // Ready is gated by rst_n so nothing is offered while reset is held.
    always_comb begin
        req_ready = !rst_n ? '0 : state == S_IDLE ? win : state == S_HOLD ? (req_valid & grant) : '0;
        hs = |req_ready;
        sel_idx = state == S_IDLE ? win_idx : owner;
        tx_start = state == S_LOAD;
        timeout = state == S_WAIT_BUSY && !tx_busy && timer == TMR_W'(BUSY_TIMEOUT - 1);
        done = timeout || (state == S_WAIT_DONE && busy_q && !tx_busy);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            last_owner <= IDX_W'(NUM_REQ - 1);
            owner <= '0;
            grant <= '0;
            tx_data <= '0;
            last_q <= 1'b0;
            busy_q <= 1'b0;
            timer <= '0;
            tx_err <= 1'b0;
            bytes_sent <= '0;
        end else begin
            busy_q <= tx_busy;
            case (state)
                S_IDLE, S_HOLD: if (hs) begin
                    tx_data <= req_data[int'(sel_idx)*DATA_W +: DATA_W];
                    last_q <= req_last[sel_idx];
                    state <= S_LOAD;
                    if (state == S_IDLE) begin
                        owner <= win_idx;
                        grant <= win;
                    end
                end
                S_LOAD: begin
                    timer <= '0;
                    state <= S_WAIT_BUSY;
                end
                S_WAIT_BUSY: if (tx_busy) state <= S_WAIT_DONE;
                    else if (!timeout) timer <= timer + 1'b1;
                S_WAIT_DONE: ;
                default: state <= S_IDLE;
            endcase
            // A timed-out character counts as completed so the packet still advances.
            if (done) begin
                bytes_sent <= bytes_sent + 1'b1;
                tx_err <= tx_err | timeout;
                state <= last_q ? S_IDLE : S_HOLD;
                if (last_q) begin
                    last_owner <= owner;
                    grant <= '0;
                end
            end
        end
    end
endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of byte requesters sharing one UART transmitter.
REQ-002 Parameter DATA_W, default 8: UART character width.
REQ-003 Parameter BUSY_TIMEOUT, default 16: the number of clk cycles to wait for tx_busy after tx_start.
REQ-004 The ports SHALL be as follows.
- clk  in  1  system clock (100 MHz).
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_REQ  per-requester byte-valid.
- req_data  in  NUM_REQ*DATA_W  per-requester byte; requester i occupies bits [i*DATA_W +: DATA_W].
- req_last  in  NUM_REQ  marks the final byte of a requester's packet.
- req_ready  out  NUM_REQ  byte accepted when valid and ready are both high at a posedge.
- tx_start  out  1  one-cycle start pulse to the transmitter.
- tx_data  out  DATA_W  byte to transmit; held stable from tx_start until the character completes.
- tx_busy  in  1  transmitter busy, from start bit through stop bit.
- grant  out  NUM_REQ  one-hot owner of the transmitter; all zero when idle.
- tx_err  out  1  sticky flag: tx_busy never rose after tx_start.
- bytes_sent  out  16  count of completed characters; wraps from 0xFFFF to 0.

Function
REQ-005 The FSM SHALL have the states IDLE, LOAD, WAIT_BUSY, WAIT_DONE and HOLD.
REQ-006 IDLE behaviour:
- The round-robin winner among the requesters with req_valid high gets req_ready=1, combinationally.
- The search starts at last_owner+1 and wraps modulo NUM_REQ.
- On the handshake edge: latch req_data and req_last, set grant, go to LOAD.
REQ-007 In IDLE with no req_valid high: all req_ready=0, grant=0, no state change.
REQ-008 LOAD SHALL last exactly one cycle: tx_start=1 with tx_data equal to the latched byte, then go to WAIT_BUSY.
- Latency: handshake at edge k gives tx_start high in cycle k+1.
REQ-009 WAIT_BUSY transitions:
- On tx_busy=1: go to WAIT_DONE.
- After BUSY_TIMEOUT cycles without tx_busy: set tx_err and treat the byte as completed.
REQ-010 In WAIT_DONE, a 1-to-0 transition of tx_busy SHALL increment bytes_sent by 1.
- Then go to IDLE if the latched last=1, else to HOLD.
REQ-011 HOLD behaviour:
- Only the granted requester can get req_ready=1, and only while its req_valid is high.
- A handshake latches the next byte and goes to LOAD.
- Other requesters are stalled until that requester's last byte completes.
REQ-012 On leaving to IDLE, last_owner SHALL be updated to the granted index and grant SHALL clear.
REQ-013 Outside IDLE and HOLD, all req_ready SHALL be 0, so at most one handshake happens per character.
REQ-014 A requester that drops req_valid during HOLD SHALL keep the grant; the arbiter waits indefinitely.
REQ-015 req_data and req_last SHALL be sampled only on a handshake edge; later changes do not affect tx_data.
REQ-016 Simultaneous requests in IDLE:
- Exactly one requester is granted.
- Every continuously requesting requester is granted within NUM_REQ packets.
REQ-017 tx_err SHALL be cleared only by reset.

Reset
REQ-018 Asserting rst_n=0 at any time, including mid-character, SHALL immediately force the following values:
- state IDLE;
- tx_start=0, tx_data=0, grant=0, req_ready=0;
- tx_err=0, bytes_sent=0;
- last_owner=NUM_REQ-1, so requester 0 has highest priority first.
REQ-019 A packet interrupted by reset SHALL be abandoned, not resumed.

Structure
REQ-020 A shared package uart_arb_pkg SHALL hold the FSM state encoding, the default DATA_W, and the bytes_sent width constant.
REQ-021 The round-robin selection SHALL be a sub-module rr_picker.
- Inputs: request vector, last_owner.
- Outputs: one-hot winner and index.
- Purely combinational, parameterised by NUM_REQ.

Verification
REQ-022 The bench model transmitter SHALL raise tx_busy 1 cycle after tx_start and hold it for 10 baud periods.
REQ-023 Directed scenarios:
- Single byte: req 2 sends 0x54 with last=1 → one tx_start carrying 0x54, grant=0b0100, then bytes_sent=1 and grant=0.
- Contention: all 4 requesters hold valid with last=1 (bytes 0x41, 0x4D, 0x49, 0x54) → service order 0,1,2,3, then 0 again.
- Packet lock: req 1 sends "TAMIM" with last only on the final 'M' while req 0 is also valid → all five characters go out before req 0 is granted.
- Timeout: tx_busy tied low → after 16 cycles in WAIT_BUSY, tx_err=1, bytes_sent=1, and the arbiter returns to IDLE or HOLD.
- Reset mid-character: rst_n pulsed low during WAIT_DONE → all outputs at reset values in the same cycle; the next request from req 0 is granted first.
- Wrap: bytes_sent preloaded via force to 0xFFFF, one byte sent → bytes_sent=0x0000.
